// File: rtl/sprite_blitter_if.sv
// Command, sprite-memory and frame-buffer signals of the sprite blitter.
// The blitter connects through the slave modport; the system side (command
// source, sprite memory, frame-buffer arbiter) uses the master modport.
interface sprite_blitter_if #(
  parameter int FB_AW  = 19,
  parameter int SPR_AW = 12,
  parameter int CI_W   = 3
) ();
  logic              cmd_valid;
  logic              cmd_ready;
  logic [9:0]        cmd_x;
  logic [9:0]        cmd_y;
  logic [3:0]        cmd_sprite;
  logic              cmd_flip;
  logic [SPR_AW-1:0] spr_addr;
  logic [CI_W-1:0]   spr_q;
  logic              fb_grant;
  logic [FB_AW-1:0]  fb_addr;
  logic [CI_W-1:0]   fb_data;
  logic              fb_wren;
  logic              done;

  modport master (
    output cmd_valid, cmd_x, cmd_y, cmd_sprite, cmd_flip, spr_q, fb_grant,
    input  cmd_ready, spr_addr, fb_addr, fb_data, fb_wren, done
  );

  modport slave (
    input  cmd_valid, cmd_x, cmd_y, cmd_sprite, cmd_flip, spr_q, fb_grant,
    output cmd_ready, spr_addr, fb_addr, fb_data, fb_wren, done
  );
endinterface

// File: rtl/sprite_blitter.sv
// Sprite blitter: copies one SPR_W x SPR_H sprite into the frame buffer at
// (x, y), skipping colour index 0, clipping at the right/bottom screen edge
// and optionally mirroring horizontally. One pixel per granted cycle.
//
// state | meaning
// IDLE  | ready for a command
// RUN   | issuing sprite reads, writing the previous pixel each granted cycle
// DRAIN | writing the last pending pixel
// DONE  | one-cycle completion pulse
module sprite_blitter #(
  parameter int FB_W   = 640,
  parameter int FB_H   = 480,
  parameter int FB_AW  = 19,
  parameter int SPR_W  = 16,
  parameter int SPR_H  = 16,
  parameter int SPR_AW = 12,
  parameter int CI_W   = 3
) (
  input logic             Clk,
  input logic             Reset,
  sprite_blitter_if.slave bus
);

  localparam int CW = $clog2(SPR_W);
  localparam int RW = $clog2(SPR_H);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   col_q, col_d;
  logic [RW-1:0]   row_q, row_d;
  logic [9:0]      x_q, y_q;
  logic [3:0]      sprite_q;
  logic            flip_q;

  // write stage: one pixel in flight between the sprite read and the fb write
  logic            stage_valid_q;
  logic            stage_in_q;
  logic [FB_AW-1:0] fb_addr_q;
  logic            fresh_q;
  logic [CI_W-1:0] hold_q;

  logic            accept;
  logic            issue;
  logic            retire;
  logic            last_px;
  logic [CW-1:0]   col_sel;
  logic [10:0]     dx, dy;
  logic [CI_W-1:0] pix;

  assign accept  = (state_q == S_IDLE) && bus.cmd_valid;
  assign issue   = (state_q == S_RUN) && bus.fb_grant;
  assign retire  = ((state_q == S_RUN) || (state_q == S_DRAIN)) && bus.fb_grant;
  assign last_px = (row_q == RW'(SPR_H - 1)) && (col_q == CW'(SPR_W - 1));
  assign col_sel = flip_q ? (CW'(SPR_W - 1) - col_q) : col_q;

  // destination of the pixel being read now; 11 bits so x+col never wraps
  assign dx = 11'(x_q) + 11'(col_q);
  assign dy = 11'(y_q) + 11'(row_q);

  // spr_q only reflects the pending pixel on the cycle right after its read;
  // during a stall the address has already moved on, so replay the held copy
  assign pix = fresh_q ? bus.spr_q : hold_q;

  assign bus.spr_addr  = SPR_AW'(sprite_q) * SPR_AW'(SPR_W * SPR_H)
                       + SPR_AW'(row_q) * SPR_AW'(SPR_W)
                       + SPR_AW'(col_sel);
  assign bus.cmd_ready = (state_q == S_IDLE);
  assign bus.done      = (state_q == S_DONE);
  assign bus.fb_addr   = fb_addr_q;
  assign bus.fb_data   = stage_valid_q ? pix : '0;
  assign bus.fb_wren   = retire && stage_valid_q && stage_in_q && (pix != '0);

  // state and sprite position counters
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= S_IDLE;
      col_q   <= '0;
      row_q   <= '0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
    end
  end

  // next state and counter stepping; everything holds while not granted
  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = S_RUN;
          col_d   = '0;
          row_d   = '0;
        end
      end
      S_RUN: begin
        if (bus.fb_grant) begin
          if (last_px) begin
            state_d = S_DRAIN;
            col_d   = '0;
            row_d   = '0;
          end else if (col_q == CW'(SPR_W - 1)) begin
            col_d = '0;
            row_d = row_q + 1'b1;
          end else begin
            col_d = col_q + 1'b1;
          end
        end
      end
      S_DRAIN: begin
        if (bus.fb_grant) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // command latch
  always_ff @(posedge Clk) begin
    if (Reset) begin
      x_q      <= '0;
      y_q      <= '0;
      sprite_q <= '0;
      flip_q   <= 1'b0;
    end else if (accept) begin
      x_q      <= bus.cmd_x;
      y_q      <= bus.cmd_y;
      sprite_q <= bus.cmd_sprite;
      flip_q   <= bus.cmd_flip;
    end
  end

  // write stage: load on each issued read, empty after the drain write
  always_ff @(posedge Clk) begin
    if (Reset) begin
      stage_valid_q <= 1'b0;
      stage_in_q    <= 1'b0;
      fb_addr_q     <= '0;
      fresh_q       <= 1'b0;
      hold_q        <= '0;
    end else begin
      if (issue) begin
        stage_valid_q <= 1'b1;
        stage_in_q    <= (dx < 11'(FB_W)) && (dy < 11'(FB_H));
        fb_addr_q     <= FB_AW'(dy) * FB_AW'(FB_W) + FB_AW'(dx);
      end else if ((state_q == S_DRAIN) && bus.fb_grant) begin
        stage_valid_q <= 1'b0;
      end
      fresh_q <= issue;
      hold_q  <= pix;
    end
  end

endmodule

// File: tb/tb_sprite_blitter.sv
// Self-checking bench for sprite_blitter: a sprite memory model, a write
// monitor and a reference that builds the expected write list directly from
// the blit rules (transparency, clipping, flip, raster order).
module tb_sprite_blitter;
  localparam int FB_W = 640, FB_H = 480, FB_AW = 19, SPR_AW = 12, CI_W = 3;
  localparam int BLIT_DONE = 258;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sprite_blitter_if #(.FB_AW(FB_AW), .SPR_AW(SPR_AW), .CI_W(CI_W)) bus ();
  sprite_blitter dut (.Clk(clk), .Reset(rst), .bus(bus));

  logic [CI_W-1:0] mem [0:4095];
  int cyc = 0;
  int checks = 0;
  int failures = 0;
  int gmode = 0;
  int phase = 0;
  logic [3:0] patt = 4'b1001;
  int acc_q[$];
  int done_q[$];
  int wc_q[$];
  logic [FB_AW+CI_W-1:0] wr_q[$];
  logic [FB_AW+CI_W-1:0] exp_q[$];
  bit grant_hist[int];
  int viol = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // synchronous sprite memory, 1-cycle latency
  always @(posedge clk) bus.spr_q <= mem[bus.spr_addr];

  // grant: 0 = always, 1 = repeating 1,0,0,1, 2 = random
  always @(posedge clk) begin
    #1;
    case (gmode)
      1: begin bus.fb_grant = patt[phase]; phase = (phase + 1) % 4; end
      2: bus.fb_grant = 1'($urandom_range(0, 1));
      default: bus.fb_grant = 1'b1;
    endcase
  end

  // monitor, sampled mid-cycle
  always @(negedge clk) begin
    grant_hist[cyc] = bus.fb_grant;
    if (!rst && bus.cmd_valid && bus.cmd_ready) acc_q.push_back(cyc);
    if (bus.fb_wren) begin
      wr_q.push_back({bus.fb_addr, bus.fb_data});
      wc_q.push_back(cyc);
      if (!bus.fb_grant) viol++;
    end
    if (bus.done) done_q.push_back(cyc);
  end

  task automatic clear_logs();
    acc_q.delete(); done_q.delete(); wc_q.delete();
    wr_q.delete(); exp_q.delete(); viol = 0;
  endtask

  // reference: expected writes in raster order for one blit
  task automatic add_expected(input int x, input int y, input int s, input int f);
    for (int r = 0; r < 16; r++) begin
      for (int c = 0; c < 16; c++) begin
        int src;
        int dxm;
        int dym;
        logic [CI_W-1:0] ci;
        src = f ? 15 - c : c;
        ci  = mem[s * 256 + r * 16 + src];
        dxm = x + c;
        dym = y + r;
        if (ci != 0 && dxm < FB_W && dym < FB_H)
          exp_q.push_back({FB_AW'(dym * FB_W + dxm), ci});
      end
    end
  endtask

  function automatic int count_diff();
    int n;
    int m;
    n = (wr_q.size() > exp_q.size()) ? wr_q.size() - exp_q.size() : exp_q.size() - wr_q.size();
    m = (wr_q.size() < exp_q.size()) ? wr_q.size() : exp_q.size();
    for (int i = 0; i < m; i++) if (wr_q[i] !== exp_q[i]) n++;
    return n;
  endfunction

  // done arrives the cycle after the 257th granted cycle (256 reads + drain)
  function automatic int model_done(input int acc);
    int g = 0;
    for (int k = acc + 1; k < acc + 5000; k++) begin
      if (!grant_hist.exists(k)) return -1;
      if (grant_hist[k]) g++;
      if (g == 257) return k + 1;
    end
    return -1;
  endfunction

  task automatic start_cmd(input int x, input int y, input int s, input int f, output int acc);
    int n0;
    n0 = acc_q.size();
    acc = -1;
    @(posedge clk); #1;
    bus.cmd_x = 10'(x); bus.cmd_y = 10'(y); bus.cmd_sprite = 4'(s); bus.cmd_flip = 1'(f);
    bus.cmd_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk); #1;
      if (acc_q.size() > n0) break;
    end
    checks++;
    if (acc_q.size() > n0) acc = acc_q[n0];
    else begin failures++; $display("FAIL accept_timeout: got no accept, required accept within 50 cycles"); end
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_dones(input int n, input int bound);
    for (int i = 0; i < bound; i++) begin
      if (done_q.size() >= n) break;
      @(negedge clk); #1;
    end
    checks++;
    if (done_q.size() < n) begin
      failures++;
      $display("FAIL done_timeout: got %0d done pulses, required %0d", done_q.size(), n);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.cmd_valid = 1'b0; bus.cmd_x = '0; bus.cmd_y = '0; bus.cmd_sprite = '0; bus.cmd_flip = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk); #1;
    checks++; if (bus.cmd_ready !== 1'b1) begin failures++; $display("FAIL rst_ready: got %b required 1", bus.cmd_ready); end
    checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL rst_done: got %b required 0", bus.done); end
    checks++; if (bus.fb_wren !== 1'b0) begin failures++; $display("FAIL rst_wren: got %b required 0", bus.fb_wren); end
    checks++; if (bus.spr_addr !== '0) begin failures++; $display("FAIL rst_spr_addr: got %0d required 0", bus.spr_addr); end
    checks++; if (bus.fb_addr !== '0) begin failures++; $display("FAIL rst_fb_addr: got %0d required 0", bus.fb_addr); end
    checks++; if (bus.fb_data !== '0) begin failures++; $display("FAIL rst_fb_data: got %0d required 0", bus.fb_data); end
  endtask

  task automatic test_opaque_origin();
    int acc;
    clear_logs(); gmode = 0;
    add_expected(0, 0, 0, 0);
    start_cmd(0, 0, 0, 0, acc);
    wait_dones(1, 400);
    checks++; if (done_q.size() < 1 || done_q[0] - acc != BLIT_DONE) begin failures++;
      $display("FAIL origin_done_cycle: got %0d required %0d", (done_q.size() > 0) ? done_q[0] - acc : -1, BLIT_DONE); end
    @(negedge clk); #1;
    checks++; if (bus.cmd_ready !== 1'b1 || bus.done !== 1'b0) begin failures++;
      $display("FAIL origin_ready_259: got ready=%b done=%b required ready=1 done=0", bus.cmd_ready, bus.done); end
    checks++; if (wr_q.size() != 256) begin failures++; $display("FAIL origin_count: got %0d required 256", wr_q.size()); end
    checks++; if (count_diff() != 0) begin failures++; $display("FAIL origin_writes: got %0d mismatches required 0", count_diff()); end
    checks++; if (wc_q.size() < 1 || wc_q[0] - acc != 2 || wc_q[wc_q.size()-1] - acc != 257) begin failures++;
      $display("FAIL origin_write_window: got first/last offset %0d/%0d required 2/257",
               (wc_q.size() > 0) ? wc_q[0] - acc : -1, (wc_q.size() > 0) ? wc_q[wc_q.size()-1] - acc : -1); end
  endtask

  task automatic test_transparency(input int f);
    int acc;
    int bad_col;
    clear_logs(); gmode = 0;
    add_expected(100, 50, 1, f);
    start_cmd(100, 50, 1, f, acc);
    wait_dones(1, 400);
    checks++; if (wr_q.size() != 128) begin failures++; $display("FAIL transp_count flip=%0d: got %0d required 128", f, wr_q.size()); end
    checks++; if (count_diff() != 0) begin failures++; $display("FAIL transp_writes flip=%0d: got %0d mismatches required 0", f, count_diff()); end
    bad_col = 0;
    foreach (wr_q[i]) begin
      int col;
      col = int'(wr_q[i][FB_AW+CI_W-1:CI_W]) % FB_W;
      if (f ? (col < 100 || col > 107) : (col < 108 || col > 115)) bad_col++;
      if (wr_q[i][CI_W-1:0] != 3'd3) bad_col++;
    end
    checks++; if (bad_col != 0) begin failures++; $display("FAIL transp_columns flip=%0d: got %0d bad writes required 0", f, bad_col); end
    if (f == 0) begin
      checks++; if (wr_q.size() < 1 || wr_q[0][FB_AW+CI_W-1:CI_W] != 19'd32108) begin failures++;
        $display("FAIL transp_first_addr: got %0d required 32108", (wr_q.size() > 0) ? int'(wr_q[0][FB_AW+CI_W-1:CI_W]) : -1); end
    end
  endtask

  task automatic test_clip();
    int acc;
    int maxa;
    clear_logs(); gmode = 0;
    add_expected(632, 472, 2, 0);
    start_cmd(632, 472, 2, 0, acc);
    wait_dones(1, 400);
    maxa = 0;
    foreach (wr_q[i]) if (int'(wr_q[i][FB_AW+CI_W-1:CI_W]) > maxa) maxa = int'(wr_q[i][FB_AW+CI_W-1:CI_W]);
    checks++; if (wr_q.size() != 64) begin failures++; $display("FAIL clip_count: got %0d required 64", wr_q.size()); end
    checks++; if (count_diff() != 0) begin failures++; $display("FAIL clip_writes: got %0d mismatches required 0", count_diff()); end
    checks++; if (maxa >= FB_W * FB_H) begin failures++; $display("FAIL clip_max_addr: got %0d required < 307200", maxa); end
    checks++; if (done_q.size() != 1) begin failures++; $display("FAIL clip_done: got %0d pulses required 1", done_q.size()); end
  endtask

  task automatic test_offscreen();
    int acc;
    clear_logs(); gmode = 0;
    start_cmd(700, 10, 2, 0, acc);
    wait_dones(1, 400);
    checks++; if (wr_q.size() != 0) begin failures++; $display("FAIL offscreen_count: got %0d required 0", wr_q.size()); end
    checks++; if (done_q.size() < 1 || done_q[0] - acc != BLIT_DONE) begin failures++;
      $display("FAIL offscreen_done: got %0d required %0d", (done_q.size() > 0) ? done_q[0] - acc : -1, BLIT_DONE); end
  endtask

  task automatic test_blit(input int x, input int y, input int s, input int f, input int gm, input string nm);
    int acc;
    int ed;
    clear_logs(); gmode = gm;
    add_expected(x, y, s, f);
    start_cmd(x, y, s, f, acc);
    wait_dones(1, 1500);
    ed = model_done(acc);
    checks++; if (count_diff() != 0) begin failures++; $display("FAIL %s_writes: got %0d mismatches required 0", nm, count_diff()); end
    checks++; if (viol != 0) begin failures++; $display("FAIL %s_wren_no_grant: got %0d required 0", nm, viol); end
    checks++; if (done_q.size() < 1 || done_q[0] != ed) begin failures++;
      $display("FAIL %s_done_cycle: got %0d required %0d", nm, (done_q.size() > 0) ? done_q[0] - acc : -1, ed - acc); end
    gmode = 0;
  endtask

  task automatic test_reset_mid();
    int acc;
    int late;
    clear_logs(); gmode = 0;
    start_cmd(10, 10, 2, 0, acc);
    while (cyc != acc + 40) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk); #1;
    checks++; if (bus.cmd_ready !== 1'b1) begin failures++; $display("FAIL abort_ready: got %b required 1", bus.cmd_ready); end
    repeat (300) @(negedge clk);
    late = 0;
    foreach (wc_q[i]) if (wc_q[i] >= acc + 41) late++;
    checks++; if (late != 0) begin failures++; $display("FAIL abort_writes: got %0d required 0", late); end
    checks++; if (done_q.size() != 0) begin failures++; $display("FAIL abort_done: got %0d required 0", done_q.size()); end
    test_blit(300, 200, 3, 1, 0, "after_abort");
  endtask

  task automatic test_back_to_back();
    int a1;
    int a2;
    clear_logs(); gmode = 0;
    add_expected(20, 30, 4, 0);
    add_expected(40, 60, 5, 1);
    @(posedge clk); #1;
    bus.cmd_x = 10'd20; bus.cmd_y = 10'd30; bus.cmd_sprite = 4'd4; bus.cmd_flip = 1'b0;
    bus.cmd_valid = 1'b1;
    for (int i = 0; i < 50 && acc_q.size() < 1; i++) begin @(negedge clk); #1; end
    @(posedge clk); #1;
    bus.cmd_x = 10'd40; bus.cmd_y = 10'd60; bus.cmd_sprite = 4'd5; bus.cmd_flip = 1'b1;
    for (int i = 0; i < 600 && acc_q.size() < 2; i++) begin @(negedge clk); #1; end
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    wait_dones(2, 600);
    a1 = (acc_q.size() > 0) ? acc_q[0] : -1;
    a2 = (acc_q.size() > 1) ? acc_q[1] : -1;
    checks++; if (done_q.size() < 1 || a2 != done_q[0] + 1 || done_q[0] != a1 + BLIT_DONE) begin failures++;
      $display("FAIL b2b_accept: got second accept %0d after first, required %0d", a2 - a1, BLIT_DONE + 1); end
    checks++; if (count_diff() != 0) begin failures++; $display("FAIL b2b_writes: got %0d mismatches required 0", count_diff()); end
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) begin
      int s;
      int c;
      s = i / 256;
      c = i % 16;
      if (s == 0) mem[i] = 3'd5;
      else if (s == 1) mem[i] = (c < 8) ? 3'd0 : 3'd3;
      else if (s == 2) mem[i] = 3'($urandom_range(1, 7));
      else mem[i] = 3'($urandom_range(0, 7));
    end
    test_reset();
    test_opaque_origin();
    test_transparency(0);
    test_transparency(1);
    test_clip();
    test_offscreen();
    test_blit(200, 100, 3, 0, 1, "stall");
    test_blit(630, 470, 6, 1, 1, "stall_clip");
    test_reset_mid();
    test_back_to_back();
    for (int k = 0; k < 4; k++) begin
      test_blit(int'($urandom_range(0, 700)), int'($urandom_range(0, 500)),
                int'($urandom_range(0, 15)), int'($urandom_range(0, 1)),
                int'($urandom_range(0, 2)), "random");
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
